// File: rtl/icache_dm_ctrl.sv
// icache_dm_ctrl: fetch controller in front of a direct-mapped instruction cache
// storage array. A hit returns the stored word. A miss fetches the word from
// backing memory, writes it into storage and forwards it to the CPU in the same
// cycle. Hit and miss statistics counters saturate at their maximum value.
//
// state    | meaning
// IDLE     | waiting for cpu_req; the fetch address is latched on accept
// LOOKUP   | storage read strobe issued for addr_q
// CHECK    | storage result sampled; a hit returns the word, a miss goes to memory
// MEM_WAIT | mem_req held until mem_ack; the returned word is captured in data_q
// FILL     | word written to storage and forwarded to the CPU
module icache_dm_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_busy,
  output logic                  cpu_valid,
  output logic [WORD_WIDTH-1:0] cpu_rdata,
  output logic                  st_read,
  output logic                  st_write,
  output logic [ADDR_WIDTH-1:0] st_address,
  output logic [WORD_WIDTH-1:0] st_wdata,
  input  logic                  st_hit,
  input  logic [WORD_WIDTH-1:0] st_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [COUNT_W-1:0]    hit_count,
  output logic [COUNT_W-1:0]    miss_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_CHECK    = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FILL     = 3'd4
  } state_e;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [COUNT_W-1:0]    hit_count_q, hit_count_d;
  logic [COUNT_W-1:0]    miss_count_q, miss_count_d;

  // State and datapath registers; reset returns to IDLE and clears everything,
  // which also drops mem_req and st_write asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (cpu_req) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = S_CHECK;
      S_CHECK:    state_d = st_hit ? S_IDLE : S_MEM_WAIT;
      S_MEM_WAIT: if (mem_ack) state_d = S_FILL;
      S_FILL:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Per-state strobes; only one of st_read/st_write/mem_req can be high.
  always_comb begin
    cpu_busy  = 1'b1;
    cpu_valid = 1'b0;
    st_read   = 1'b0;
    st_write  = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      S_IDLE:     cpu_busy  = 1'b0;
      S_LOOKUP:   st_read   = 1'b1;
      S_CHECK:    cpu_valid = st_hit;
      S_MEM_WAIT: mem_req   = 1'b1;
      S_FILL: begin
        st_write  = 1'b1;
        cpu_valid = 1'b1;
      end
      default:    cpu_busy  = 1'b0;
    endcase
  end

  // Returned word: storage word on a hit, refill word in FILL, otherwise the
  // last word delivered so the CPU sees a stable value between fetches.
  always_comb begin
    cpu_rdata = rdata_q;
    if (state_q == S_FILL) begin
      cpu_rdata = data_q;
    end else if (cpu_valid) begin
      cpu_rdata = st_rdata;
    end
  end

  // Address/data latches and saturating statistics counters.
  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == S_IDLE) && cpu_req) begin
      addr_d = cpu_addr;
    end
    if ((state_q == S_MEM_WAIT) && mem_ack) begin
      data_d = mem_rdata;
    end
    if (cpu_valid) begin
      rdata_d = cpu_rdata;
    end
    if (state_q == S_CHECK) begin
      if (st_hit) begin
        if (hit_count_q != COUNT_MAX) hit_count_d = hit_count_q + COUNT_ONE;
      end else begin
        if (miss_count_q != COUNT_MAX) miss_count_d = miss_count_q + COUNT_ONE;
      end
    end
  end

  assign st_address = addr_q;
  assign st_wdata   = data_q;
  assign mem_addr   = addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Bench for icache_dm_ctrl: a storage-array emulator plus a transaction-level
// model of the expected output timeline, with one per-cycle compare process.
module tb_icache_dm_ctrl;
  localparam int WW   = 32;
  localparam int AW   = 32;
  localparam int CW   = 2;
  localparam int IB   = 4;
  localparam int NSET = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req, cpu_busy, cpu_valid;
  logic [AW-1:0] cpu_addr, st_address, mem_addr;
  logic [WW-1:0] cpu_rdata, st_wdata, st_rdata, mem_rdata;
  logic          st_read, st_write, st_hit, mem_req, mem_ack;
  logic [CW-1:0] hit_count, miss_count;

  icache_dm_ctrl #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_busy(cpu_busy),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .st_read(st_read), .st_write(st_write), .st_address(st_address),
    .st_wdata(st_wdata), .st_hit(st_hit), .st_rdata(st_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_write  = 0;
  int n_mreq   = 0;

  // Storage array emulator: registered read, write on st_write, cleared by reset.
  logic          stg_valid [NSET];
  logic [AW-1:0] stg_tag   [NSET];
  logic [WW-1:0] stg_data  [NSET];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSET; i++) stg_valid[i] <= 1'b0;
      st_hit   <= 1'b0;
      st_rdata <= '0;
    end else begin
      if (st_write) begin
        stg_valid[st_address[IB-1:0]] <= 1'b1;
        stg_tag[st_address[IB-1:0]]   <= st_address >> IB;
        stg_data[st_address[IB-1:0]]  <= st_wdata;
      end
      if (st_read) begin
        if (stg_valid[st_address[IB-1:0]] && (stg_tag[st_address[IB-1:0]] == (st_address >> IB))) begin
          st_hit   <= 1'b1;
          st_rdata <= stg_data[st_address[IB-1:0]];
        end else begin
          st_hit   <= 1'b0;
          st_rdata <= $urandom;
        end
      end else begin
        st_hit   <= 1'($urandom_range(0, 1));
        st_rdata <= $urandom;
      end
    end
  end

  // Reference model state.
  logic          model_valid [NSET];
  logic [AW-1:0] model_tag   [NSET];
  int            exp_hit, exp_miss;
  logic [WW-1:0] model_rdata, exp_wdata;
  logic [AW-1:0] model_addr;
  bit            exp_busy, exp_valid, exp_st_read, exp_st_write, exp_mem_req;
  bit            chk_en = 1'b0;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h0000_0004) return 32'hDEAD_BEEF;
    if (a == 32'h0000_0014) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : CMAX;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input bit busy, input bit valid, input bit rd, input bit wr, input bit mreq);
    exp_busy = busy; exp_valid = valid; exp_st_read = rd;
    exp_st_write = wr; exp_mem_req = mreq;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSET; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
    end
    exp_hit = 0; exp_miss = 0;
    model_rdata = '0; model_addr = '0; exp_wdata = '0;
    set_exp(0, 0, 0, 0, 0);
  endtask

  // Per-cycle compare of every output against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_busy", cpu_busy, exp_busy);
      check("cpu_valid", cpu_valid, exp_valid);
      check("cpu_rdata", cpu_rdata, model_rdata);
      check("st_read", st_read, exp_st_read);
      check("st_write", st_write, exp_st_write);
      check("mem_req", mem_req, exp_mem_req);
      check("st_address", st_address, model_addr);
      if (exp_mem_req) check("mem_addr", mem_addr, model_addr);
      if (exp_st_write) check("st_wdata", st_wdata, exp_wdata);
      check("hit_count", hit_count, exp_hit);
      check("miss_count", miss_count, exp_miss);
      if (cpu_valid) n_valid++;
      if (st_write) n_write++;
      if (mem_req) n_mreq++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spurious();
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_req  = 1'b0;
      cpu_addr = $urandom;
      spurious();
      set_exp(0, 0, 0, 0, 0);
      step();
    end
  endtask

  // Asserts reset mid-cycle when the fetch reaches cycle 'at', checks the
  // immediate effect, then releases reset and pulses a stale mem_ack.
  task automatic try_abort(input int cyc, input int at, output bit ab);
    ab = (cyc == at);
    if (ab) begin
      #1 reset = 1'b1;
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_busy", cpu_busy, 0);
      check("rst_valid", cpu_valid, 0);
      check("rst_st_write", st_write, 0);
      check("rst_st_read", st_read, 0);
      check("rst_hits", hit_count, 0);
      check("rst_misses", miss_count, 0);
      check("rst_rdata", cpu_rdata, 0);
      model_reset();
      cpu_req = 1'b0;
      mem_ack = 1'b0;
      step();
      step();
      reset   = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      step();
      mem_ack = 1'b0;
    end
  endtask

  // One CPU fetch starting in an IDLE cycle; d = MEM_WAIT cycles before mem_ack.
  task automatic fetch(input logic [AW-1:0] a, input int d, input int abort_at);
    int idx;
    int cyc;
    bit hit;
    bit ab;
    logic [WW-1:0] w;
    idx = int'(a[IB-1:0]);
    hit = model_valid[idx] && (model_tag[idx] == (a >> IB));
    w   = mem_word(a);
    cyc = 0;
    cpu_req = 1'b1; cpu_addr = a; spurious();
    set_exp(0, 0, 0, 0, 0);
    try_abort(cyc, abort_at, ab); if (ab) return;
    step(); cyc++;
    model_addr = a; spurious();
    set_exp(1, 0, 1, 0, 0);
    try_abort(cyc, abort_at, ab); if (ab) return;
    step(); cyc++;
    spurious();
    if (hit) begin
      model_rdata = w;
      set_exp(1, 1, 0, 0, 0);
    end else begin
      set_exp(1, 0, 0, 0, 0);
    end
    try_abort(cyc, abort_at, ab); if (ab) return;
    step(); cyc++;
    if (hit) begin
      exp_hit = sat(exp_hit);
    end else begin
      exp_miss = sat(exp_miss);
      for (int i = 0; i <= d; i++) begin
        mem_ack   = (i == d);
        mem_rdata = (i == d) ? w : WW'($urandom);
        set_exp(1, 0, 0, 0, 1);
        try_abort(cyc, abort_at, ab); if (ab) return;
        step(); cyc++;
      end
      spurious();
      exp_wdata   = w;
      model_rdata = w;
      set_exp(1, 1, 0, 1, 0);
      try_abort(cyc, abort_at, ab); if (ab) return;
      step(); cyc++;
      model_valid[idx] = 1'b1;
      model_tag[idx]   = a >> IB;
    end
    mem_ack = 1'b0;
    set_exp(0, 0, 0, 0, 0);
  endtask

  initial begin
    int w0, v0, m0;
    cpu_req = 1'b0; cpu_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_reset();
    #2 reset = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    idle(2);
    check("init_hits", hit_count, 0);
    check("init_misses", miss_count, 0);
    check("init_rdata", cpu_rdata, 0);

    // Cold miss on 0x4, memory acks on the 4th MEM_WAIT cycle.
    w0 = n_write;
    fetch(32'h4, 3, -1);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t1_misses", miss_count, 1);
    check("t1_hits", hit_count, 0);
    check("t1_writes", n_write - w0, 1);
    idle(1);

    // Warm hit on 0x4.
    m0 = n_mreq;
    fetch(32'h4, 0, -1);
    check("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t2_hits", hit_count, 1);
    check("t2_mem_req", n_mreq - m0, 0);
    idle(1);

    // Conflict on index 4.
    fetch(32'h14, 1, -1);
    check("t3_rdata_a", cpu_rdata, 32'h1234_5678);
    idle(1);
    fetch(32'h4, 0, -1);
    check("t3_rdata_b", cpu_rdata, 32'hDEAD_BEEF);
    check("t3_misses", miss_count, 3);
    idle(1);

    // Reset one cycle after mem_req rises.
    w0 = n_write; v0 = n_valid;
    fetch(32'h8, 3, 4);
    check("t4_hits", hit_count, 0);
    check("t4_misses", miss_count, 0);
    check("t4_writes", n_write - w0, 0);
    check("t4_valids", n_valid - v0, 0);
    idle(1);

    // Back-to-back hits with cpu_req held high.
    fetch(32'h4, 1, -1);
    idle(1);
    fetch(32'h4, 0, -1);
    fetch(32'h4, 0, -1);
    check("t5_hits", hit_count, 2);
    idle(1);

    // Saturation, then a spurious mem_ack while idle.
    for (int i = 0; i < 6; i++) fetch(32'h4, 0, -1);
    check("t6_hits", hit_count, 3);
    cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    set_exp(0, 0, 0, 0, 0);
    step();
    mem_ack = 1'b0;
    step();
    check("t6_hits_after_ack", hit_count, 3);
    check("t6_misses_after_ack", miss_count, 1);
    check("t6_busy_after_ack", cpu_busy, 0);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int ab_at;
      ab_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
      fetch(AW'($urandom_range(0, 63)), int'($urandom_range(0, 3)), ab_at);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
